// File: rtl/svunit_seq_pkg.sv
// Shared types and defaults for the SVUnit-style test sequencer.
//   seq_state_e : sequencer FSM states
//   verdict_e   : outcome of one RUN phase
//   idx_width   : width of an index into n slots (minimum 1)
package svunit_seq_pkg;

  localparam int unsigned DEF_NUM_TESTS      = 16;
  localparam int unsigned DEF_CNT_W          = 8;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_SETUP    = 3'd2,
    ST_RUN      = 3'd3,
    ST_TEARDOWN = 3'd4,
    ST_FINISH   = 3'd5
  } seq_state_e;

  typedef enum logic [1:0] {
    VERDICT_PASS    = 2'd0,
    VERDICT_FAIL    = 2'd1,
    VERDICT_TIMEOUT = 2'd2
  } verdict_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/svunit_seq_watchdog.sv
// RUN-phase watchdog: counts enabled cycles since the last clear.
//   clk, rst_n   : clock, async active-low reset
//   clear_i      : zero the count (held while outside RUN)
//   en_i         : count this cycle (high while in RUN)
//   expired_c_o  : combinational; high in the cycle whose edge completes
//                  TIMEOUT_CYCLES enabled cycles
module svunit_seq_watchdog import svunit_seq_pkg::*; #(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_c_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count saturates at the limit so a stalled FSM cannot wrap it
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CW'(TIMEOUT_CYCLES))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the RUN cycles already completed; this edge would be the last
  assign expired_c_o = en_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/svunit_test_sequencer.sv
// Hardware scheduler for SVUnit-style runs: walks enabled tests in index
// order, driving setup -> run -> teardown req/ack handshakes and tallying
// saturating pass/fail counts.
// Optional watchdog on RUN: define SVUNIT_SEQ_TIMEOUT_EN.
//   clk, rst_n          : clock, async active-low reset
//   start_i             : begin a run (only honoured in IDLE)
//   enable_mask_i       : per-test enable, latched at start
//   busy_o, done_o      : run in progress / one-cycle completion pulse
//   test_id_o           : test currently in setup/run/teardown
//   setup_req_o/ack_i   : setup handshake
//   run_req_o/done_i    : run handshake, run_pass_i valid with run_done_i
//   teardown_req_o/ack_i: teardown handshake
//   pass_cnt_o/fail_cnt_o: results of this run
//   timeout_o           : sticky, some RUN hit the watchdog this run
module svunit_test_sequencer import svunit_seq_pkg::*; #(
  parameter int unsigned NUM_TESTS      = DEF_NUM_TESTS,
  parameter int unsigned ID_W           = idx_width(NUM_TESTS),
  parameter int unsigned CNT_W          = DEF_CNT_W,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [NUM_TESTS-1:0] enable_mask_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [ID_W-1:0]      test_id_o,
  output logic                 setup_req_o,
  input  logic                 setup_ack_i,
  output logic                 run_req_o,
  input  logic                 run_done_i,
  input  logic                 run_pass_i,
  output logic                 teardown_req_o,
  input  logic                 teardown_ack_i,
  output logic [CNT_W-1:0]     pass_cnt_o,
  output logic [CNT_W-1:0]     fail_cnt_o,
  output logic                 timeout_o
);

  // One extra bit so the index can reach NUM_TESTS without wrapping
  localparam int unsigned IDX_W = ID_W + 1;

  seq_state_e           state_q, state_d;
  logic [NUM_TESTS-1:0] mask_q, mask_d;
  logic [IDX_W-1:0]     id_q, id_d;
  logic [CNT_W-1:0]     pass_q, pass_d, fail_q, fail_d;
  logic                 busy_q, done_q, setup_req_q, run_req_q, teardown_req_q;
  logic                 count_c;
  verdict_e             verdict_c;
  logic                 timeout_hit_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

`ifdef SVUNIT_SEQ_TIMEOUT_EN
  logic tmo_q, tmo_d;

  svunit_seq_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (state_q != ST_RUN),
    .en_i        (state_q == ST_RUN),
    .expired_c_o (timeout_hit_c)
  );

  // Sticky timeout flag; a done in the expiry cycle takes precedence
  always_comb begin
    tmo_d = tmo_q;
    if ((state_q == ST_IDLE) && start_i) begin
      tmo_d = 1'b0;
    end else if ((state_q == ST_RUN) && !run_done_i && timeout_hit_c) begin
      tmo_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign timeout_o = tmo_q;
`else
  assign timeout_hit_c = 1'b0;
  assign timeout_o     = 1'b0;
`endif

  // Next-state and datapath updates
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    id_d      = id_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    count_c   = 1'b0;
    verdict_c = VERDICT_PASS;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mask_d  = enable_mask_i;
          pass_d  = '0;
          fail_d  = '0;
          id_d    = '0;
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (id_q == IDX_W'(NUM_TESTS)) begin
          state_d = ST_FINISH;
        end else if (mask_q[id_q[ID_W-1:0]]) begin
          state_d = ST_SETUP;
        end else begin
          id_d = id_q + IDX_W'(1);
        end
      end
      ST_SETUP: begin
        if (setup_ack_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (run_done_i) begin
          count_c   = 1'b1;
          verdict_c = run_pass_i ? VERDICT_PASS : VERDICT_FAIL;
          state_d   = ST_TEARDOWN;
        end else if (timeout_hit_c) begin
          count_c   = 1'b1;
          verdict_c = VERDICT_TIMEOUT;
          state_d   = ST_TEARDOWN;
        end
      end
      ST_TEARDOWN: begin
        if (teardown_ack_i) begin
          id_d    = id_q + IDX_W'(1);
          state_d = ST_SELECT;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (count_c) begin
      if (verdict_c == VERDICT_PASS) begin
        pass_d = sat_inc(pass_q);
      end else begin
        fail_d = sat_inc(fail_q);
      end
    end
  end

  // State register; handshake/status outputs are registered from next state
  // so each req is high for exactly the cycles spent in its state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      mask_q         <= '0;
      id_q           <= '0;
      pass_q         <= '0;
      fail_q         <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      setup_req_q    <= 1'b0;
      run_req_q      <= 1'b0;
      teardown_req_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      mask_q         <= mask_d;
      id_q           <= id_d;
      pass_q         <= pass_d;
      fail_q         <= fail_d;
      busy_q         <= (state_d != ST_IDLE);
      done_q         <= (state_d == ST_FINISH);
      setup_req_q    <= (state_d == ST_SETUP);
      run_req_q      <= (state_d == ST_RUN);
      teardown_req_q <= (state_d == ST_TEARDOWN);
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign test_id_o      = id_q[ID_W-1:0];
  assign setup_req_o    = setup_req_q;
  assign run_req_o      = run_req_q;
  assign teardown_req_o = teardown_req_q;
  assign pass_cnt_o     = pass_q;
  assign fail_cnt_o     = fail_q;

endmodule

// File: tb/tb_svunit_test_sequencer.sv
// Directed bench for svunit_test_sequencer (16 tests, 2-bit counters so
// saturation is reachable, watchdog limit 8 when SVUNIT_SEQ_TIMEOUT_EN).
module tb_svunit_test_sequencer;

  localparam int unsigned NT   = 16;
  localparam int unsigned IDW  = 4;
  localparam int unsigned CW   = 2;
  localparam int unsigned TMO  = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start_i;
  logic [NT-1:0]  enable_mask_i;
  logic           busy_o, done_o;
  logic [IDW-1:0] test_id_o;
  logic           setup_req_o, setup_ack_i;
  logic           run_req_o, run_done_i, run_pass_i;
  logic           teardown_req_o, teardown_ack_i;
  logic [CW-1:0]  pass_cnt_o, fail_cnt_o;
  logic           timeout_o;

  int total = 0;
  int bad   = 0;

  svunit_test_sequencer #(
    .NUM_TESTS      (NT),
    .ID_W           (IDW),
    .CNT_W          (CW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .enable_mask_i  (enable_mask_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .test_id_o      (test_id_o),
    .setup_req_o    (setup_req_o),
    .setup_ack_i    (setup_ack_i),
    .run_req_o      (run_req_o),
    .run_done_i     (run_done_i),
    .run_pass_i     (run_pass_i),
    .teardown_req_o (teardown_req_o),
    .teardown_ack_i (teardown_ack_i),
    .pass_cnt_o     (pass_cnt_o),
    .fail_cnt_o     (fail_cnt_o),
    .timeout_o      (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel_sig(input int sel);
    case (sel)
      0:       return setup_req_o;
      1:       return run_req_o;
      2:       return teardown_req_o;
      default: return done_o;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int budget, output logic seen);
    seen = sel_sig(sel);
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = sel_sig(sel);
    end
  endtask

  task automatic start_run(input logic [NT-1:0] m);
    enable_mask_i = m;
    start_i       = 1'b1;
    tick();
    start_i       = 1'b0;
  endtask

  // Service one test with acks arriving one cycle after each req
  task automatic serve(input string tag, input logic [31:0] id, input logic pass);
    logic seen;
    wait_for(0, 40, seen);
    chk({tag, "_setup_seen"}, 32'(seen), 32'd1);
    chk({tag, "_setup_id"}, 32'(test_id_o), id);
    tick();
    setup_ack_i = 1'b1;
    tick();
    setup_ack_i = 1'b0;
    chk({tag, "_setup_drop"}, 32'(setup_req_o), 32'd0);
    chk({tag, "_run_req"}, 32'(run_req_o), 32'd1);
    tick();
    run_done_i = 1'b1;
    run_pass_i = pass;
    tick();
    run_done_i = 1'b0;
    run_pass_i = 1'b0;
    chk({tag, "_run_drop"}, 32'(run_req_o), 32'd0);
    chk({tag, "_td_req"}, 32'(teardown_req_o), 32'd1);
    tick();
    teardown_ack_i = 1'b1;
    tick();
    teardown_ack_i = 1'b0;
    chk({tag, "_td_drop"}, 32'(teardown_req_o), 32'd0);
  endtask

  task automatic finish_run(input string tag, input logic [31:0] p, input logic [31:0] f);
    logic seen;
    wait_for(3, 60, seen);
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_pass"}, 32'(pass_cnt_o), p);
    chk({tag, "_fail"}, 32'(fail_cnt_o), f);
    tick();
    chk({tag, "_done_once"}, 32'(done_o), 32'd0);
    chk({tag, "_busy_drop"}, 32'(busy_o), 32'd0);
  endtask

  // Run with every ack/done held high; optionally pulse start mid-run
  task automatic held_run(input logic [NT-1:0] m, input logic [NT-1:0] m2, input int pulse_at,
                          output int setups, output int tdowns, output int done_at);
    setup_ack_i = 1'b1; run_done_i = 1'b1; run_pass_i = 1'b1; teardown_ack_i = 1'b1;
    start_run(m);
    setups = 0; tdowns = 0; done_at = -1;
    for (int k = 1; k <= 80 && done_at < 0; k++) begin
      if (k == pulse_at) begin
        enable_mask_i = m2;
        start_i       = 1'b1;
      end
      tick();
      start_i = 1'b0;
      if (setup_req_o)    setups++;
      if (teardown_req_o) tdowns++;
      if (done_o)         done_at = k;
    end
    setup_ack_i = 1'b0; run_done_i = 1'b0; run_pass_i = 1'b0; teardown_ack_i = 1'b0;
  endtask

  initial begin
    logic seen;
    logic any_req;
    int   n, setups, tdowns, done_at;

    rst_n = 1'b1; start_i = 1'b0; enable_mask_i = '0;
    setup_ack_i = 1'b0; run_done_i = 1'b0; run_pass_i = 1'b0; teardown_ack_i = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_reqs", {29'd0, setup_req_o, run_req_o, teardown_req_o}, 32'd0);
    chk("rst_id", 32'(test_id_o), 32'd0);
    chk("rst_cnts", {28'd0, pass_cnt_o, fail_cnt_o}, 32'd0);
    chk("rst_done_tmo", {30'd0, done_o, timeout_o}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // 1: mask 0x0005, both pass; setup only for ids 0 and 2
    start_run(16'h0005);
    chk("t1_busy", 32'(busy_o), 32'd1);
    chk("t1_setup_early", 32'(setup_req_o), 32'd0);
    tick();
    chk("t1_setup_latency", 32'(setup_req_o), 32'd1);
    serve("t1_id0", 32'd0, 1'b1);
    serve("t1_id2", 32'd2, 1'b1);
    finish_run("t1", 32'd2, 32'd0);

    // 2: id0 fails, id1 passes; teardown still issued for id0
    start_run(16'h0003);
    chk("t2_cnt_clear", 32'(pass_cnt_o), 32'd0);
    serve("t2_id0", 32'd0, 1'b0);
    chk("t2_fail_mid", 32'(fail_cnt_o), 32'd1);
    serve("t2_id1", 32'd1, 1'b1);
    finish_run("t2", 32'd1, 32'd1);

    // 3: empty mask; done 17 edges after the start edge, no req ever
    start_run(16'h0000);
    any_req = 1'b0;
    done_at = -1;
    for (int k = 1; k <= 40 && done_at < 0; k++) begin
      tick();
      if (setup_req_o || run_req_o || teardown_req_o) any_req = 1'b1;
      if (done_o) done_at = k;
    end
    chk("t3_done_latency", 32'(done_at), 32'd17);
    chk("t3_no_req", 32'(any_req), 32'd0);
    chk("t3_cnts", {28'd0, pass_cnt_o, fail_cnt_o}, 32'd0);
    tick();

    // 4: RUN never completes
    start_run(16'h0001);
    wait_for(0, 40, seen);
    chk("t4_setup_seen", 32'(seen), 32'd1);
    tick();
    setup_ack_i = 1'b1;
    tick();
    setup_ack_i = 1'b0;
    chk("t4_run_req", 32'(run_req_o), 32'd1);
`ifdef SVUNIT_SEQ_TIMEOUT_EN
    n = 0;
    while (run_req_o && n < 50) begin
      tick();
      n++;
    end
    chk("t4_run_cycles", 32'(n), 32'(TMO));
    chk("t4_timeout", 32'(timeout_o), 32'd1);
    chk("t4_td_after_tmo", 32'(teardown_req_o), 32'd1);
    chk("t4_fail", 32'(fail_cnt_o), 32'd1);
    tick();
    teardown_ack_i = 1'b1;
    tick();
    teardown_ack_i = 1'b0;
    finish_run("t4", 32'd0, 32'd1);
    chk("t4_timeout_sticky", 32'(timeout_o), 32'd1);
`else
    for (int k = 0; k < 3 * TMO; k++) tick();
    chk("t4_run_waits", 32'(run_req_o), 32'd1);
    chk("t4_no_timeout", 32'(timeout_o), 32'd0);
    run_done_i = 1'b1;
    run_pass_i = 1'b1;
    tick();
    run_done_i = 1'b0;
    run_pass_i = 1'b0;
    chk("t4_td_req", 32'(teardown_req_o), 32'd1);
    tick();
    teardown_ack_i = 1'b1;
    tick();
    teardown_ack_i = 1'b0;
    finish_run("t4", 32'd1, 32'd0);
`endif

    // 5: reset while id1 is in RUN, then a clean rerun
    start_run(16'h0003);
    chk("t5_timeout_clear", 32'(timeout_o), 32'd0);
    serve("t5_id0", 32'd0, 1'b1);
    wait_for(0, 40, seen);
    tick();
    setup_ack_i = 1'b1;
    tick();
    setup_ack_i = 1'b0;
    chk("t5_in_run", 32'(run_req_o), 32'd1);
    chk("t5_pass_before", 32'(pass_cnt_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_async_run", 32'(run_req_o), 32'd0);
    chk("t5_async_busy", 32'(busy_o), 32'd0);
    chk("t5_async_id", 32'(test_id_o), 32'd0);
    chk("t5_async_pass", 32'(pass_cnt_o), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_no_teardown", 32'(teardown_req_o), 32'd0);
    start_run(16'h0002);
    serve("t5_rerun", 32'd1, 1'b0);
    finish_run("t5", 32'd0, 32'd1);

    // 6: acks held high, start pulsed while busy
    held_run(16'h0003, 16'hFFFF, 3, setups, tdowns, done_at);
    chk("t6_setups", 32'(setups), 32'd2);
    chk("t6_teardowns", 32'(tdowns), 32'd2);
    chk("t6_done_at", 32'(done_at), 32'd23);
    chk("t6_pass", 32'(pass_cnt_o), 32'd2);
    tick();
    chk("t6_idle", 32'(busy_o), 32'd0);

    // 7: five passes including the last slot; 2-bit counter saturates at 3
    held_run(16'h800F, 16'h0000, 0, setups, tdowns, done_at);
    chk("t7_setups", 32'(setups), 32'd5);
    chk("t7_done_at", 32'(done_at), 32'd32);
    chk("t7_pass_sat", 32'(pass_cnt_o), 32'd3);
    chk("t7_fail", 32'(fail_cnt_o), 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
